// File: rtl/i2s_audio_rx.sv
// I2S receiver: deserialises a codec-mastered I2S stream into 24-bit stereo pairs
// with a one-cycle valid strobe in the sys_clk domain.
`timescale 1ns/100fs
module i2s_audio_rx #(
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned SLOT_MAX = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_sdata,
    output logic [DATA_W-1:0] sample_l,
    output logic [DATA_W-1:0] sample_r,
    output logic              sample_vld,
    output logic              frame_err
);

    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned SLOT_W = $clog2(SLOT_MAX + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_SHIFT,
        ST_PAD
    } state_e;

    logic [2:0]        bclk_sync_q;
    logic [1:0]        lrck_sync_q;
    logic [1:0]        sdata_sync_q;

    state_e            state_q,      state_d;
    logic              ch_q,         ch_d;
    logic [BIT_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic [SLOT_W-1:0] slot_cnt_q,   slot_cnt_d;
    logic              lr_prev_q,    lr_prev_d;
    logic [DATA_W-1:0] shreg_q,      shreg_d;
    logic [DATA_W-1:0] hold_l_q,     hold_l_d;
    logic [DATA_W-1:0] sample_l_q,   sample_l_d;
    logic [DATA_W-1:0] sample_r_q,   sample_r_d;
    logic              sample_vld_q, sample_vld_d;
    logic              frame_err_q,  frame_err_d;

    logic              bclk_rise;
    logic              lrck_s;
    logic              sdata_s;
    logic              lr_chg;
    logic              word_done;
    logic              overrun;
    logic [DATA_W-1:0] shreg_shift;

    assign bclk_rise   = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign lrck_s      = lrck_sync_q[1];
    assign sdata_s     = sdata_sync_q[1];
    assign lr_chg      = lrck_s ^ lr_prev_q;
    assign word_done   = (bit_cnt_q == BIT_W'(DATA_W - 1));
    assign overrun     = (state_q != ST_IDLE) && !lr_chg && (slot_cnt_q >= SLOT_W'(SLOT_MAX));
    assign shreg_shift = {shreg_q[DATA_W-2:0], sdata_s};

    // Synchronisers plus all FSM/datapath state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            bclk_sync_q  <= '0;
            lrck_sync_q  <= '0;
            sdata_sync_q <= '0;
            state_q      <= ST_IDLE;
            ch_q         <= 1'b0;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            lr_prev_q    <= 1'b0;
            shreg_q      <= '0;
            hold_l_q     <= '0;
            sample_l_q   <= '0;
            sample_r_q   <= '0;
            sample_vld_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            bclk_sync_q  <= {bclk_sync_q[1:0], i2s_bclk};
            lrck_sync_q  <= {lrck_sync_q[0], i2s_lrck};
            sdata_sync_q <= {sdata_sync_q[0], i2s_sdata};
            state_q      <= state_d;
            ch_q         <= ch_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            lr_prev_q    <= lr_prev_d;
            shreg_q      <= shreg_d;
            hold_l_q     <= hold_l_d;
            sample_l_q   <= sample_l_d;
            sample_r_q   <= sample_r_d;
            sample_vld_q <= sample_vld_d;
            frame_err_q  <= frame_err_d;
        end
    end

    // Next-state logic; everything advances only on a synchronised bclk rising edge.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        bit_cnt_d    = bit_cnt_q;
        slot_cnt_d   = slot_cnt_q;
        lr_prev_d    = lr_prev_q;
        shreg_d      = shreg_q;
        hold_l_d     = hold_l_q;
        sample_l_d   = sample_l_q;
        sample_r_d   = sample_r_q;
        sample_vld_d = 1'b0;
        frame_err_d  = frame_err_q;

        if (bclk_rise) begin
            lr_prev_d = lrck_s;
            if (lr_chg) begin
                slot_cnt_d = '0;
            end else if (slot_cnt_q != SLOT_W'(SLOT_MAX + 1)) begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
            end

            if (overrun) begin
                frame_err_d = 1'b1;
                state_d     = ST_IDLE;
                bit_cnt_d   = '0;
                ch_d        = 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (lr_prev_q && !lrck_s) begin
                            state_d   = ST_DELAY;
                            bit_cnt_d = '0;
                            ch_d      = 1'b0;
                        end
                    end
                    // The bit seen with the lrck edge is the delay slot; DELAY holds the MSB next.
                    ST_DELAY, ST_SHIFT: begin
                        shreg_d = shreg_shift;
                        if (word_done) begin
                            bit_cnt_d = BIT_W'(DATA_W);
                            state_d   = ST_PAD;
                            if (!ch_q) begin
                                hold_l_d = shreg_shift;
                            end else begin
                                sample_l_d   = hold_l_q;
                                sample_r_d   = shreg_shift;
                                sample_vld_d = 1'b1;
                            end
                            if (lr_chg) begin
                                state_d   = ST_DELAY;
                                ch_d      = ~ch_q;
                                bit_cnt_d = '0;
                            end
                        end else if (lr_chg) begin
                            frame_err_d = 1'b1;
                            shreg_d     = '0;
                            hold_l_d    = '0;
                            bit_cnt_d   = '0;
                            ch_d        = 1'b0;
                            state_d     = lrck_s ? ST_IDLE : ST_DELAY;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            state_d   = ST_SHIFT;
                        end
                    end
                    ST_PAD: begin
                        if (lr_chg) begin
                            state_d   = ST_DELAY;
                            ch_d      = ~ch_q;
                            bit_cnt_d = '0;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    assign sample_l   = sample_l_q;
    assign sample_r   = sample_r_q;
    assign sample_vld = sample_vld_q;
    assign frame_err  = frame_err_q;

endmodule
